// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch (IF)
// stage and the load/store (MEM) stage of the pipeline. Requests from the two
// stages are serialised onto a registered req/ack memory handshake. A
// combinational stall output freezes the PC and the stage registers while a
// requester is still waiting for its access to complete.
//
// Parameters
//   WIDTH        data and address width
//   TIMEOUT_CYC  maximum number of cycles o_mem_req waits for i_mem_ack
//                before the access is aborted (1..255)
//
// Ports
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_if_req           fetch request, level, held until o_if_valid
//   i_if_addr          fetch address (PC)
//   o_if_rdata         fetched instruction, valid with o_if_valid
//   o_if_valid         one-cycle fetch completion pulse
//   i_dm_req           data request, level, held until o_dm_valid
//   i_dm_we            1 = store, 0 = load
//   i_dm_addr          data address
//   i_dm_wdata         store data
//   o_dm_rdata         load data, valid with o_dm_valid (0 for stores)
//   o_dm_valid         one-cycle data completion pulse
//   o_stall            pipeline freeze
//   o_mem_req/we/addr/wdata  registered memory request
//   i_mem_rdata        memory read data, sampled on ack
//   i_mem_ack          one-cycle memory completion
//   o_timeout          sticky flag: some access was aborted on timeout
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_if_req,
    input  logic [WIDTH-1:0] i_if_addr,
    output logic [WIDTH-1:0] o_if_rdata,
    output logic             o_if_valid,
    input  logic             i_dm_req,
    input  logic             i_dm_we,
    input  logic [WIDTH-1:0] i_dm_addr,
    input  logic [WIDTH-1:0] i_dm_wdata,
    output logic [WIDTH-1:0] o_dm_rdata,
    output logic             o_dm_valid,
    output logic             o_stall,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic [WIDTH-1:0] i_mem_rdata,
    input  logic             i_mem_ack,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

    // The wait counter holds the number of busy cycles already spent without
    // an ack, so the access expires in the busy cycle where it equals this.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            state_next;
    grant_t            last_grant;
    grant_t            last_grant_next;
    logic [7:0]        wait_cnt;
    logic [7:0]        wait_cnt_next;

    logic              mem_req_next;
    logic              mem_we_next;
    logic [WIDTH-1:0]  mem_addr_next;
    logic [WIDTH-1:0]  mem_wdata_next;
    logic [WIDTH-1:0]  if_rdata_next;
    logic              if_valid_next;
    logic [WIDTH-1:0]  dm_rdata_next;
    logic              dm_valid_next;
    logic              timeout_next;

    logic              if_eligible;
    logic              dm_eligible;
    logic              ack_taken;
    logic              expired;

    // A requester keeps its request high during its own completion cycle, so
    // it must not be granted again while its valid pulse is out.
    assign if_eligible = i_if_req & ~o_if_valid;
    assign dm_eligible = i_dm_req & ~o_dm_valid;

    // An ack only counts while a request is actually on the memory bus.
    assign ack_taken = i_mem_ack & o_mem_req;
    assign expired   = (wait_cnt == WAIT_LAST);

    assign o_stall = (i_if_req & ~o_if_valid) | (i_dm_req & ~o_dm_valid);

    // State and output registers. Reset is asynchronous so the memory
    // request drops immediately and any in-flight access is forgotten.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            last_grant  <= GRANT_IF;
            wait_cnt    <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_if_rdata  <= '0;
            o_if_valid  <= 1'b0;
            o_dm_rdata  <= '0;
            o_dm_valid  <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state       <= state_next;
            last_grant  <= last_grant_next;
            wait_cnt    <= wait_cnt_next;
            o_mem_req   <= mem_req_next;
            o_mem_we    <= mem_we_next;
            o_mem_addr  <= mem_addr_next;
            o_mem_wdata <= mem_wdata_next;
            o_if_rdata  <= if_rdata_next;
            o_if_valid  <= if_valid_next;
            o_dm_rdata  <= dm_rdata_next;
            o_dm_valid  <= dm_valid_next;
            o_timeout   <= timeout_next;
        end
    end

    // Next-state and next-output logic. Everything holds by default except
    // the valid pulses, which are single-cycle.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        wait_cnt_next   = wait_cnt;
        mem_req_next    = o_mem_req;
        mem_we_next     = o_mem_we;
        mem_addr_next   = o_mem_addr;
        mem_wdata_next  = o_mem_wdata;
        if_rdata_next   = o_if_rdata;
        if_valid_next   = 1'b0;
        dm_rdata_next   = o_dm_rdata;
        dm_valid_next   = 1'b0;
        timeout_next    = o_timeout;

        unique case (state)
            IDLE: begin
                // Data wins a tie unless the previous grant went to data and
                // a fetch is waiting; this alternates under sustained load.
                if (dm_eligible && (last_grant == GRANT_IF || !if_eligible)) begin
                    state_next      = DATA;
                    last_grant_next = GRANT_DM;
                    wait_cnt_next   = '0;
                    mem_req_next    = 1'b1;
                    mem_we_next     = i_dm_we;
                    mem_addr_next   = i_dm_addr;
                    mem_wdata_next  = i_dm_wdata;
                end else if (if_eligible) begin
                    state_next      = FETCH;
                    last_grant_next = GRANT_IF;
                    wait_cnt_next   = '0;
                    mem_req_next    = 1'b1;
                    mem_we_next     = 1'b0;
                    mem_addr_next   = i_if_addr;
                    mem_wdata_next  = '0;
                end
            end

            FETCH: begin
                // An ack in the expiry cycle still completes normally.
                if (ack_taken) begin
                    state_next    = IDLE;
                    mem_req_next  = 1'b0;
                    if_rdata_next = i_mem_rdata;
                    if_valid_next = 1'b1;
                end else if (expired) begin
                    state_next    = IDLE;
                    mem_req_next  = 1'b0;
                    if_rdata_next = '0;
                    if_valid_next = 1'b1;
                    timeout_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end

            DATA: begin
                // Stores report zero read data; the memory's rdata bus is
                // meaningless for a write.
                if (ack_taken) begin
                    state_next    = IDLE;
                    mem_req_next  = 1'b0;
                    dm_rdata_next = o_mem_we ? '0 : i_mem_rdata;
                    dm_valid_next = 1'b1;
                end else if (expired) begin
                    state_next    = IDLE;
                    mem_req_next  = 1'b0;
                    dm_rdata_next = '0;
                    dm_valid_next = 1'b1;
                    timeout_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

endmodule
